// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants, FSM state type and the maximal-length tap table
// used by every LFSR instance in the codebase.
package lfsr_pkg;

    localparam int LFSR_MIN_N = 3;
    localparam int LFSR_MAX_N = 32;
    localparam int LFSR_LEN_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lfsr_state_t;

    // Builds a mask from up to four 1-based stage numbers; 0 means "unused".
    function automatic logic [31:0] tap_bits(input int a, input int b, input int c, input int d);
        logic [31:0] m;
        m = '0;
        if (a > 0) m = m | (32'd1 << (a - 1));
        if (b > 0) m = m | (32'd1 << (b - 1));
        if (c > 0) m = m | (32'd1 << (c - 1));
        if (d > 0) m = m | (32'd1 << (d - 1));
        return m;
    endfunction

    // Maximal-length feedback taps; bit k-1 of the result selects stage k.
    function automatic logic [31:0] taps_mask(input int n);
        case (n)
            3:       return tap_bits(3, 2, 0, 0);
            4:       return tap_bits(4, 3, 0, 0);
            5:       return tap_bits(5, 3, 0, 0);
            6:       return tap_bits(6, 5, 0, 0);
            7:       return tap_bits(7, 6, 0, 0);
            8:       return tap_bits(8, 6, 5, 4);
            9:       return tap_bits(9, 5, 0, 0);
            10:      return tap_bits(10, 7, 0, 0);
            11:      return tap_bits(11, 9, 0, 0);
            12:      return tap_bits(12, 6, 4, 1);
            13:      return tap_bits(13, 4, 3, 1);
            14:      return tap_bits(14, 5, 3, 1);
            15:      return tap_bits(15, 14, 0, 0);
            16:      return tap_bits(16, 15, 13, 4);
            17:      return tap_bits(17, 14, 0, 0);
            18:      return tap_bits(18, 11, 0, 0);
            19:      return tap_bits(19, 6, 2, 1);
            20:      return tap_bits(20, 17, 0, 0);
            21:      return tap_bits(21, 19, 0, 0);
            22:      return tap_bits(22, 21, 0, 0);
            23:      return tap_bits(23, 18, 0, 0);
            24:      return tap_bits(24, 23, 22, 17);
            25:      return tap_bits(25, 22, 0, 0);
            26:      return tap_bits(26, 6, 2, 1);
            27:      return tap_bits(27, 5, 2, 1);
            28:      return tap_bits(28, 25, 0, 0);
            29:      return tap_bits(29, 27, 0, 0);
            30:      return tap_bits(30, 6, 4, 1);
            31:      return tap_bits(31, 28, 0, 0);
            32:      return tap_bits(32, 22, 2, 1);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational Fibonacci next-state plus lockup-safe seed.
// Bit index i of a vector holds stage i+1, so stage 1 is bit 0.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int N    = 8,
    parameter bit XNOR = 1'b0
) (
    input  logic [N-1:0] cur,
    input  logic [N-1:0] seed,
    output logic [N-1:0] nxt,
    output logic [N-1:0] seed_safe
);

    localparam logic [31:0]  MASK   = taps_mask(N);
    localparam logic [N-1:0] TAPS   = MASK[N-1:0];
    localparam logic [N-1:0] LOCKUP = XNOR ? {N{1'b1}} : {N{1'b0}};
    localparam logic [N-1:0] Q_ONE  = {{(N-1){1'b0}}, 1'b1};

    logic fb;

    // Feedback is the parity of the tapped stages, inverted in XNOR mode.
    always_comb begin
        fb        = (^(cur & TAPS)) ^ XNOR;
        nxt       = {cur[N-2:0], fb};
        seed_safe = (seed == LOCKUP) ? Q_ONE : seed;
    end

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci PRBS generator with seed load, free-run
// stepping, counted bursts and wrap detection against the last loaded state.
// Optional macro LFSR_PERIOD_CNT_EN adds the period output and step counter.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int N    = 8,
    parameter bit XNOR = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [N-1:0]          seed,
    input  logic                  start,
    input  logic [LFSR_LEN_W-1:0] len,
    output logic [N-1:0]          q,
    output logic                  bit_out,
    output logic                  bit_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap
`ifdef LFSR_PERIOD_CNT_EN
    ,
    output logic [N-1:0]          period
`endif
);

    if ((N < LFSR_MIN_N) || (N > LFSR_MAX_N)) begin : g_n_check
        $error("lfsr_gen: N must be within 3..32");
    end

    localparam logic [N-1:0]          Q_ONE   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [LFSR_LEN_W-1:0] CNT_ONE = {{(LFSR_LEN_W-1){1'b0}}, 1'b1};

    lfsr_state_t           state, state_nxt;
    logic [N-1:0]          q_r, ref_r, q_nxt, seed_safe;
    logic [LFSR_LEN_W-1:0] cnt;
    logic                  run, step, start_ok, done_nxt, wrap_hit;

    lfsr_step #(.N(N), .XNOR(XNOR)) u_step (
        .cur       (q_r),
        .seed      (seed),
        .nxt       (q_nxt),
        .seed_safe (seed_safe)
    );

    // Load overrides both stepping and burst start.
    assign run      = (state == RUN);
    assign start_ok = !load && !run && start && (len != '0);
    assign step     = !load && (run || en);
    assign wrap_hit = step && (q_nxt == ref_r);

    // Next-state: bursts end after the counter's last cycle or on load abort.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: if (start_ok) state_nxt = RUN;
            RUN: begin
                if (load) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_ONE) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state and the registered one-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            done  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            wrap  <= wrap_hit;
        end
    end

    // Shift register and reference value; both take the sanitised seed on load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r   <= Q_ONE;
            ref_r <= Q_ONE;
        end else if (load) begin
            q_r   <= seed_safe;
            ref_r <= seed_safe;
        end else if (step) begin
            q_r   <= q_nxt;
        end
    end

    // Burst counter: loaded on accepted start, counts down while running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (start_ok) begin
            cnt <= len;
        end else if (run && !load) begin
            cnt <= cnt - CNT_ONE;
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [N-1:0] step_cnt, step_cnt_inc;

    assign step_cnt_inc = step_cnt + Q_ONE;

    // Steps since the last reference hit; latched into period on each wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_cnt <= '0;
            period   <= '0;
        end else if (load) begin
            step_cnt <= '0;
        end else if (step) begin
            if (wrap_hit) begin
                period   <= step_cnt_inc;
                step_cnt <= '0;
            end else begin
                step_cnt <= step_cnt_inc;
            end
        end
    end
`endif

    assign q         = q_r;
    assign bit_out   = q_r[N-1];
    assign bit_valid = run;
    assign busy      = run;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: four lfsr_gen configurations driven by shared stimulus and
// compared every cycle against a stage-list reference model.
module tb_lfsr_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0, load = 1'b0, start = 1'b0;
    logic [31:0] seed = '0;
    logic [15:0] len = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    logic [2:0]  q0;
    logic [7:0]  q1, q2;
    logic [15:0] q3;
    logic [3:0]  bo, bv, bz, dn, wr;
    logic [31:0] dq [4];

    assign dq[0] = {29'b0, q0};
    assign dq[1] = {24'b0, q1};
    assign dq[2] = {24'b0, q2};
    assign dq[3] = {16'b0, q3};

`ifdef LFSR_PERIOD_CNT_EN
    logic [2:0]  p0;
    logic [7:0]  p1, p2;
    logic [15:0] p3;
    logic [31:0] dp [4];
    assign dp[0] = {29'b0, p0};
    assign dp[1] = {24'b0, p1};
    assign dp[2] = {24'b0, p2};
    assign dp[3] = {16'b0, p3};
`endif

    lfsr_gen #(.N(3), .XNOR(1'b0)) u3 (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed(seed[2:0]),
        .start(start), .len(len), .q(q0), .bit_out(bo[0]), .bit_valid(bv[0]),
        .busy(bz[0]), .done(dn[0]), .wrap(wr[0])
`ifdef LFSR_PERIOD_CNT_EN
        , .period(p0)
`endif
    );

    lfsr_gen #(.N(8), .XNOR(1'b0)) u8 (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed(seed[7:0]),
        .start(start), .len(len), .q(q1), .bit_out(bo[1]), .bit_valid(bv[1]),
        .busy(bz[1]), .done(dn[1]), .wrap(wr[1])
`ifdef LFSR_PERIOD_CNT_EN
        , .period(p1)
`endif
    );

    lfsr_gen #(.N(8), .XNOR(1'b1)) u8n (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed(seed[7:0]),
        .start(start), .len(len), .q(q2), .bit_out(bo[2]), .bit_valid(bv[2]),
        .busy(bz[2]), .done(dn[2]), .wrap(wr[2])
`ifdef LFSR_PERIOD_CNT_EN
        , .period(p2)
`endif
    );

    lfsr_gen #(.N(16), .XNOR(1'b0)) u16 (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed(seed[15:0]),
        .start(start), .len(len), .q(q3), .bit_out(bo[3]), .bit_valid(bv[3]),
        .busy(bz[3]), .done(dn[3]), .wrap(wr[3])
`ifdef LFSR_PERIOD_CNT_EN
        , .period(p3)
`endif
    );

    // ---------------- reference model ----------------
    logic [31:0] m_q [4], m_ref [4], m_per [4], m_sc [4];
    bit          m_run [4], m_done [4], m_wrap [4];
    int          m_cnt [4];

    function automatic int n_of(input int k);
        case (k)
            0:       return 3;
            1, 2:    return 8;
            default: return 16;
        endcase
    endfunction

    function automatic bit x_of(input int k);
        return (k == 2);
    endfunction

    function automatic logic [31:0] nmask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    // Stage k+1 takes stage k; stage 1 takes the parity of the tapped stages.
    function automatic logic [31:0] model_next(input int n, input bit xn, input logic [31:0] v);
        int t [4];
        bit fb;
        case (n)
            3:       t = '{3, 2, 0, 0};
            8:       t = '{8, 6, 5, 4};
            default: t = '{16, 15, 13, 4};
        endcase
        fb = xn;
        for (int i = 0; i < 4; i++)
            if (t[i] > 0) fb = fb ^ v[t[i]-1];
        return ((v << 1) | {31'b0, fb}) & nmask(n);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_q[k] = 1; m_ref[k] = 1; m_per[k] = 0; m_sc[k] = 0;
            m_run[k] = 0; m_done[k] = 0; m_wrap[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_clock();
        for (int k = 0; k < 4; k++) begin
            int n;
            bit stepping;
            logic [31:0] s, lock;
            n    = n_of(k);
            s    = seed & nmask(n);
            lock = x_of(k) ? nmask(n) : 32'd0;
            if (load) begin
                m_q[k]    = (s == lock) ? 32'd1 : s;
                m_ref[k]  = m_q[k];
                m_run[k]  = 0;
                m_done[k] = 0;
                m_wrap[k] = 0;
                m_sc[k]   = 0;
            end else begin
                stepping  = m_run[k] || en;
                m_done[k] = 0;
                m_wrap[k] = 0;
                if (m_run[k]) begin
                    m_cnt[k]--;
                    if (m_cnt[k] == 0) begin
                        m_run[k]  = 0;
                        m_done[k] = 1;
                    end
                end else if (start && len != 0) begin
                    m_run[k] = 1;
                    m_cnt[k] = int'(len);
                end
                if (stepping) begin
                    m_q[k]  = model_next(n, x_of(k), m_q[k]);
                    m_sc[k] = (m_sc[k] + 1) & nmask(n);
                    if (m_q[k] == m_ref[k]) begin
                        m_wrap[k] = 1;
                        m_per[k]  = m_sc[k];
                        m_sc[k]   = 0;
                    end
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("q[%0d]", k),     dq[k],           m_q[k]);
            check($sformatf("bit_out[%0d]", k), 32'(bo[k]),    32'(m_q[k][n_of(k)-1]));
            check($sformatf("valid[%0d]", k), 32'(bv[k]),      32'(m_run[k]));
            check($sformatf("busy[%0d]", k),  32'(bz[k]),      32'(m_run[k]));
            check($sformatf("done[%0d]", k),  32'(dn[k]),      32'(m_done[k]));
            check($sformatf("wrap[%0d]", k),  32'(wr[k]),      32'(m_wrap[k]));
`ifdef LFSR_PERIOD_CNT_EN
            check($sformatf("period[%0d]", k), dp[k],          m_per[k]);
`endif
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] exp3 [7];
        logic [31:0] bits4 [4];
        int r;
        exp3  = '{32'd2, 32'd5, 32'd3, 32'd7, 32'd6, 32'd4, 32'd1};
        bits4 = '{32'd0, 32'd0, 32'd1, 32'd0};

        model_reset();
        #12;
        compare_all();
        check("rst_q3", dq[0], 32'd1);
        reset_n = 1'b1;

        // N=3 free run through a full period
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycle();
            check("seq3", dq[0], exp3[i]);
            check("seq3_wrap", 32'(wr[0]), (i == 6) ? 32'd1 : 32'd0);
        end
        en = 1'b0;

        // N=3 burst of 4 bits from state 001
        start = 1'b1; len = 16'd4;
        cycle();
        start = 1'b0; len = 16'd0;
        for (int i = 0; i < 4; i++) begin
            check("burst_valid", 32'(bv[0]), 32'd1);
            check("burst_bit", 32'(bo[0]), bits4[i]);
            cycle();
        end
        check("burst_done", 32'(dn[0]), 32'd1);
        check("burst_busy", 32'(bz[0]), 32'd0);
        cycle();
        check("burst_done_once", 32'(dn[0]), 32'd0);

        // lockup-value seeds
        load = 1'b1; seed = 32'h0;
        cycle();
        check("lock_xor_q", dq[1], 32'h01);
        check("lock_xor_wrap", 32'(wr[1]), 32'd0);
        seed = 32'hFF;
        cycle();
        load = 1'b0;
        check("lock_xnor_q", dq[2], 32'h01);
        check("lock_xnor_wrap", 32'(wr[2]), 32'd0);
        cycle();

        // N=16 burst aborted by load after 10 bits
        start = 1'b1; len = 16'd100;
        cycle();
        start = 1'b0; len = 16'd0;
        repeat (10) cycle();
        check("abort_pre_valid", 32'(bv[3]), 32'd1);
        load = 1'b1; seed = 32'hACE1;
        cycle();
        load = 1'b0;
        check("abort_q", dq[3], 32'hACE1);
        check("abort_valid", 32'(bv[3]), 32'd0);
        check("abort_busy", 32'(bz[3]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("abort_no_done", 32'(dn[3]), 32'd0);
        end

        // load beats start in the same cycle; start with len=0 is ignored
        load = 1'b1; start = 1'b1; len = 16'd5; seed = 32'h5;
        cycle();
        load = 1'b0; start = 1'b0; len = 16'd0;
        check("ld_start_busy", 32'(bz[0]), 32'd0);
        check("ld_start_q", dq[0], 32'd5);
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("len0_valid", 32'(bv[1]), 32'd0);
            check("len0_done", 32'(dn[1]), 32'd0);
            cycle();
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en    = 1'($urandom_range(0, 1));
            load  = ($urandom_range(0, 19) == 0);
            start = ($urandom_range(0, 3) == 0);
            len   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
            r     = int'($urandom_range(0, 3));
            seed  = (r == 0) ? 32'h0 : (r == 1) ? 32'hFFFF_FFFF : $urandom;
            cycle();
        end
        en = 1'b0; load = 1'b0; start = 1'b0; len = 16'd0;

`ifdef LFSR_PERIOD_CNT_EN
        // full-period measurement from a known reference
        load = 1'b1; seed = 32'h1;
        cycle();
        load = 1'b0; en = 1'b1;
        repeat (255) cycle();
        check("period8", dp[1], 32'd255);
        repeat (65535 - 255) cycle();
        check("period16", dp[3], 32'd65535);
        en = 1'b0;
`endif

        cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
